pkt_word_packer: RTL

- Upstream neighbour of unpacker_fsm.
- Accepts a narrow packet byte stream (IN_B bytes per beat) and packs consecutive beats into wide OUT_B-byte words with val/sop/eop/vbc framing.
- Respects the downstream ready, so unpacker_fsm is driven by this block instead of a bench.

---
 rtl/pkt_word_packer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pkt_word_packer.sv
// Packs a narrow packet beat stream into wide output words.
// Output words carry val/sop/eop/vbc framing and honour downstream ready.
module pkt_word_packer #(
   parameter int unsigned IN_B  = 32,
   parameter int unsigned OUT_B = 160
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 in_val,
   input  logic                 in_sop,
   input  logic                 in_eop,
   input  logic [5:0]           in_vbc,
   input  logic [IN_B*8-1:0]    in_data,
   output logic                 in_ready,
   output logic                 val,
   output logic                 sop,
   output logic                 eop,
   output logic [7:0]           vbc,
   output logic [OUT_B*8-1:0]   data,
   input  logic                 ready,
   output logic                 err
);

   localparam int unsigned BEATS = OUT_B / IN_B;
   localparam int unsigned IN_W  = IN_B * 8;
   localparam int unsigned OUT_W = OUT_B * 8;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [OUT_W-1:0]   acc, acc_nxt;
   logic               acc_sop, acc_sop_nxt;
   logic               acc_eop, acc_eop_nxt;
   logic [7:0]         acc_vbc, acc_vbc_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               in_pkt, in_pkt_nxt;
   logic               val_nxt, sop_nxt, eop_nxt, in_ready_nxt, err_nxt;
   logic [7:0]         vbc_nxt;
   logic [OUT_W-1:0]   data_nxt;

   logic               beat_acc, beat_ok, start, out_free, closing;
   logic               vbc_bad, short_mid, proto_err;
   logic [5:0]         eff_vbc;
   logic [IN_W-1:0]    beat_data;
   logic [OUT_W-1:0]   new_word;
   logic               new_sop;
   logic [7:0]         new_vbc;

   // Decode the presented beat and build the word it would complete
   always_comb begin
      beat_acc  = in_val && in_ready;
      out_free  = !val || ready;
      start     = in_sop && !in_pkt;
      beat_ok   = beat_acc && (in_pkt || in_sop);
      vbc_bad   = (in_vbc == 6'd0) || (in_vbc > 6'(IN_B));
      short_mid = !in_eop && (in_vbc != 6'(IN_B));
      eff_vbc   = (vbc_bad || short_mid) ? 6'(IN_B) : in_vbc;
      closing   = beat_ok && (in_eop || (cnt == CNT_W'(BEATS - 1)));
      proto_err = beat_acc && (!(in_pkt || in_sop) || (in_sop && in_pkt) || vbc_bad || short_mid);
      beat_data = '0;
      for (int i = 0; i < int'(IN_B); i++) begin
         if (6'(i) < eff_vbc) beat_data[i*8 +: 8] = in_data[i*8 +: 8];
      end
      new_word = acc;
      for (int k = 0; k < int'(BEATS); k++) begin
         if (cnt == CNT_W'(k)) new_word[k*IN_W +: IN_W] = beat_data;
      end
      new_sop = (cnt == '0) ? start : acc_sop;
      new_vbc = 8'(IN_B) * 8'(cnt) + 8'(eff_vbc);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state <= FILL;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL: if (closing && !out_free) state_nxt = HOLD;
         HOLD: if (out_free)             state_nxt = FILL;
      endcase
   end

   // Next values of the output word, accumulator and packet tracking
   always_comb begin
      val_nxt      = val && !ready;
      sop_nxt      = sop;
      eop_nxt      = eop;
      vbc_nxt      = vbc;
      data_nxt     = data;
      acc_nxt      = acc;
      acc_sop_nxt  = acc_sop;
      acc_eop_nxt  = acc_eop;
      acc_vbc_nxt  = acc_vbc;
      cnt_nxt      = cnt;
      in_pkt_nxt   = in_pkt;
      err_nxt      = err || proto_err;
      in_ready_nxt = (state_nxt == FILL);

      if (beat_ok) begin
         if (in_eop)     in_pkt_nxt = 1'b0;
         else if (start) in_pkt_nxt = 1'b1;
      end

      case (state)
         FILL: begin
            if (beat_ok && !closing) begin
               acc_nxt     = new_word;
               acc_sop_nxt = new_sop;
               cnt_nxt     = cnt + CNT_W'(1);
            end else if (closing && out_free) begin
               val_nxt     = 1'b1;
               sop_nxt     = new_sop;
               eop_nxt     = in_eop;
               vbc_nxt     = new_vbc;
               data_nxt    = new_word;
               acc_nxt     = '0;
               acc_sop_nxt = 1'b0;
               cnt_nxt     = '0;
            end else if (closing) begin
               acc_nxt     = new_word;
               acc_sop_nxt = new_sop;
               acc_eop_nxt = in_eop;
               acc_vbc_nxt = new_vbc;
               cnt_nxt     = '0;
            end
         end
         HOLD: begin
            if (out_free) begin
               val_nxt     = 1'b1;
               sop_nxt     = acc_sop;
               eop_nxt     = acc_eop;
               vbc_nxt     = acc_vbc;
               data_nxt    = acc;
               acc_nxt     = '0;
               acc_sop_nxt = 1'b0;
               cnt_nxt     = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         val      <= 1'b0;
         sop      <= 1'b0;
         eop      <= 1'b0;
         vbc      <= '0;
         data     <= '0;
         in_ready <= 1'b0;
         err      <= 1'b0;
         acc      <= '0;
         acc_sop  <= 1'b0;
         acc_eop  <= 1'b0;
         acc_vbc  <= '0;
         cnt      <= '0;
         in_pkt   <= 1'b0;
      end else begin
         val      <= val_nxt;
         sop      <= sop_nxt;
         eop      <= eop_nxt;
         vbc      <= vbc_nxt;
         data     <= data_nxt;
         in_ready <= in_ready_nxt;
         err      <= err_nxt;
         acc      <= acc_nxt;
         acc_sop  <= acc_sop_nxt;
         acc_eop  <= acc_eop_nxt;
         acc_vbc  <= acc_vbc_nxt;
         cnt      <= cnt_nxt;
         in_pkt   <= in_pkt_nxt;
      end
   end

endmodule
